led_pwm_fade: RTL and testbench
===============================

# led_pwm_fade

Per-channel PWM dimmer with linear fade for the RGB LED, placed directly downstream of the blink generator. It takes the three on/off LED requests blink produces and turns each edge into a smooth brightness ramp: up on a rising request, down on a falling one. Its outputs drive the RGB LED pads in place of the raw blink signals.

## Interface
- p_width, 8, PWM and brightness-level resolution in bits; level range 0..2^p_width-1
- p_bit_step, 10, fade prescaler width; one level step every 2^p_bit_step clocks
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous, active-low reset
- i_en_r  input  1  red on-request, from blink o_led_r; same clock domain
- i_en_g  input  1  green on-request, from blink o_led_g
- i_en_b  input  1  blue on-request, from blink o_led_b
- o_led_r  output  1  red PWM drive, active-high
- o_led_g  output  1  green PWM drive, active-high
- o_led_b  output  1  blue PWM drive, active-high
- o_busy  output  1  high while any channel is in RISE or FALL

## Operation
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst.
- Reset (i_rst=0 at a clock edge):
  - All levels 0, all FSMs in OFF.
  - r_pwm=0, r_div=0.
  - o_led_*=0, o_busy=0.
  - A reset mid-fade aborts the fade with no residual state.
- Enable capture: i_en_* registered once (r_en_*); FSMs act on the registered copy.
- Prescaler r_div (p_bit_step bits):
  - Free-running, wraps all-ones to 0.
  - Tick is a one-cycle pulse while r_div is all-ones.
- PWM counter r_pwm (p_width bits): free-running, wraps 2^p_width-1 to 0, independent of the prescaler.
- Per-channel FSM, states OFF/RISE/ON/FALL, each channel independent:
  - OFF (level=0): r_en=1 goes to RISE.
  - RISE: on a tick, level+1; reaching max goes to ON. r_en=0 goes to FALL and keeps the current level.
  - ON (level=max): r_en=0 goes to FALL.
  - FALL: on a tick, level-1; reaching 0 goes to OFF. r_en=1 goes to RISE and keeps the current level.
  - State changes take effect on any cycle. Level changes only on a tick.
  - Level never wraps: it saturates at 0 and at max.
- Duty: duty = level, p_width bits.
- Output: o_led_x is the registered value of (duty_x > r_pwm).
  - Level 0: always off.
  - Level max: high 2^p_width-1 of every 2^p_width cycles.
- o_busy: registered OR over channels of (state==RISE || state==FALL).

## Timing
- i_en edge to FSM state change: 2 cycles (input register, then state register).
- Tick to new level: the level register updates on the tick cycle edge. The new level reaches o_led one cycle later.
- Full ramp 0 to max: (2^p_width-1) ticks, ~(2^p_width-1)*2^p_bit_step clocks. Defaults: 255*1024 = 261120 clocks. The first step falls on the first tick after entry, so the step phase is not aligned to i_en.
- PWM period: 2^p_width clocks. The duty compare uses the current level each cycle, with no period-boundary latching.
- Simultaneous tick and direction change: the state change wins. No step is taken in the old direction on that cycle. The new direction steps on the next tick.
- Simultaneous reset and anything: reset wins.

## Configuration
- LED_FADE_GAMMA_EN defined:
  - duty = (level*level) >> p_width, using a 2*p_width-bit intermediate product.
  - Gives a perceptually linear fade.
  - Max level yields duty 2^p_width-2 (for p_width ≥ 2).
- LED_FADE_GAMMA_EN undefined: duty = level, linear. No multiplier is inferred.
- FSM, timing and reset behaviour are identical either way.

## Test plan
All scenarios use p_width=4, p_bit_step=2 (tick every 4 clocks, PWM period 16).
- Reset hold: i_rst=0 for 5 cycles with all i_en=1 -> o_led_*=0 and o_busy=0 throughout; fade starts only after i_rst=1.
- Full rise: i_en_r=1 after reset -> o_busy=1 within 3 cycles; red level reaches 15 after 15 ticks (~60 clocks); o_busy then falls; o_led_r is high 15 of every 16 cycles; g/b stay 0.
- Reversal: drop i_en_r when level=6 during RISE -> next level is 5, then 4 ... 0; never above 6; OFF after 6 ticks; o_led_r constantly 0 afterwards.
- Duty check, no macro: hold level 8 (ON with max forced, or sample mid-rise) -> o_led_r high exactly 8 of 16 cycles per PWM period.
- Gamma, LED_FADE_GAMMA_EN defined: level 8 -> duty 4, high 4 of 16 cycles; level 15 -> duty 14.
- Reset mid-fade: assert i_rst=0 during the FALL of all three channels -> next cycle all levels 0, o_led_*=0, o_busy=0.

Source files
------------

// File: rtl/led_pwm_fade.sv
// led_pwm_fade: RGB PWM dimmer that fades each channel linearly up/down on its on-request edge.
// Define LED_FADE_GAMMA_EN to square the level into a perceptually linear duty.
module led_pwm_fade #(
    parameter int p_width = 8,
    parameter int p_bit_step = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en_r,
    input  logic i_en_g,
    input  logic i_en_b,
    output logic o_led_r,
    output logic o_led_g,
    output logic o_led_b,
    output logic o_busy
);
    typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;
    localparam logic [p_width-1:0] lvl_max = '1;
    logic [2:0] r_en;
    logic [2:0] led;
    logic [2:0] busy;
    logic [p_bit_step-1:0] r_div;
    logic [p_width-1:0] r_pwm;
    logic r_busy;
    logic tick;
    assign tick = &r_div;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_en <= '0;
            r_div <= '0;
            r_pwm <= '0;
            r_busy <= 1'b0;
        end else begin
            r_en <= {i_en_b, i_en_g, i_en_r};
            r_div <= r_div + 1'b1;
            r_pwm <= r_pwm + 1'b1;
            r_busy <= |busy;
        end
    end
    genvar c;
    generate
        for (c = 0; c < 3; c++) begin : g_ch
            state_t r_state, state_nxt;
            logic [p_width-1:0] r_lvl, lvl_nxt, duty;
            logic r_led;
            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    r_state <= OFF;
                    r_lvl <= '0;
                    r_led <= 1'b0;
                end else begin
                    r_state <= state_nxt;
                    r_lvl <= lvl_nxt;
                    r_led <= duty > r_pwm;
                end
            end
            // a direction change takes priority over a coincident tick
            always_comb begin
                state_nxt = r_state;
                lvl_nxt = r_lvl;
                case (r_state)
                    OFF: state_nxt = r_en[c] ? RISE : OFF;
                    RISE: begin
                        if (!r_en[c]) state_nxt = FALL;
                        else if (r_lvl == lvl_max) state_nxt = ON;
                        else if (tick) begin
                            lvl_nxt = r_lvl + 1'b1;
                            state_nxt = (lvl_nxt == lvl_max) ? ON : RISE;
                        end
                    end
                    ON: state_nxt = r_en[c] ? ON : FALL;
                    FALL: begin
                        if (r_en[c]) state_nxt = RISE;
                        else if (r_lvl == '0) state_nxt = OFF;
                        else if (tick) begin
                            lvl_nxt = r_lvl - 1'b1;
                            state_nxt = (lvl_nxt == '0) ? OFF : FALL;
                        end
                    end
                    default: state_nxt = OFF;
                endcase
            end
`ifdef LED_FADE_GAMMA_EN
            logic [2*p_width-1:0] sq;
            assign sq = {{p_width{1'b0}}, r_lvl} * {{p_width{1'b0}}, r_lvl};
            assign duty = p_width'(sq >> p_width);
`else
            assign duty = r_lvl;
`endif
            assign busy[c] = (r_state == RISE) || (r_state == FALL);
            assign led[c] = r_led;
        end
    endgenerate
    assign o_led_r = led[0];
    assign o_led_g = led[1];
    assign o_led_b = led[2];
    assign o_busy = r_busy;
endmodule

// File: tb/tb_led_pwm_fade.sv
// tb_led_pwm_fade: directed table, reversal sequence and random stimulus against a level/target model.
module tb_led_pwm_fade;
    localparam int W = 4;
    localparam int S = 2;
    localparam int MAXL = (1 << W) - 1;
    localparam int PER = 1 << W;
    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_en_r = 1'b0;
    logic i_en_g = 1'b0;
    logic i_en_b = 1'b0;
    logic o_led_r, o_led_g, o_led_b, o_busy;
    int n_chk = 0;
    int n_fail = 0;
    led_pwm_fade #(.p_width(W), .p_bit_step(S)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en_r(i_en_r), .i_en_g(i_en_g), .i_en_b(i_en_b),
        .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b), .o_busy(o_busy)
    );
    always #5 i_clk = ~i_clk;
    int m_lvl[3];
    bit m_en[3];
    bit m_dir[3];
    bit m_bs[3];
    int m_div = 0;
    int m_pwm = 0;
    bit [2:0] m_led = '0;
    bit m_busy = 1'b0;
    function automatic int duty(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l) >> W;
`else
        return l;
`endif
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // the level walks toward the target of the registered request; a request change costs that cycle's step
    task automatic cycle(input bit rst, input bit [2:0] en);
        bit tick, chg, busy_n;
        bit [2:0] led_n;
        int tgt;
        i_rst = rst;
        {i_en_b, i_en_g, i_en_r} = en;
        @(posedge i_clk);
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                m_lvl[c] = 0; m_en[c] = 0; m_dir[c] = 0; m_bs[c] = 0;
            end
            m_div = 0; m_pwm = 0; m_led = '0; m_busy = 1'b0;
        end else begin
            tick = (m_div == (1 << S) - 1);
            busy_n = m_bs[0] | m_bs[1] | m_bs[2];
            for (int c = 0; c < 3; c++) begin
                led_n[c] = duty(m_lvl[c]) > m_pwm;
                tgt = m_en[c] ? MAXL : 0;
                chg = m_en[c] != m_dir[c];
                if (!chg && tick && m_lvl[c] != tgt) m_lvl[c] += m_en[c] ? 1 : -1;
                m_dir[c] = m_en[c];
                m_bs[c] = chg || (m_lvl[c] != tgt);
                m_en[c] = en[c];
            end
            m_div = (m_div + 1) % (1 << S);
            m_pwm = (m_pwm + 1) % PER;
            m_led = led_n;
            m_busy = busy_n;
        end
        @(negedge i_clk);
        check("bgr_busy", {o_led_b, o_led_g, o_led_r, o_busy}, {m_led, m_busy});
    endtask
    typedef struct {
        bit rst;
        bit [2:0] en;
        int n;
        bit busy;
        int hi_r;
        int hi_g;
        int hi_b;
    } vec_t;
    vec_t tbl[8];
    initial begin
        int hr, hg, hb, hi, k;
        bit [2:0] en;
        tbl[0] = '{1'b0, 3'b111, 5, 1'b0, 0, 0, 0};
        tbl[1] = '{1'b1, 3'b001, 3, 1'b1, 0, 0, 0};
        tbl[2] = '{1'b1, 3'b001, 80, 1'b0, 15, 0, 0};
        tbl[3] = '{1'b1, 3'b000, 80, 1'b0, 0, 0, 0};
        tbl[4] = '{1'b1, 3'b111, 100, 1'b0, 15, 15, 15};
        tbl[5] = '{1'b1, 3'b000, 30, 1'b1, -1, -1, -1};
        tbl[6] = '{1'b0, 3'b000, 1, 1'b0, 0, 0, 0};
        tbl[7] = '{1'b1, 3'b000, 20, 1'b0, 0, 0, 0};
`ifdef LED_FADE_GAMMA_EN
        tbl[2].hi_r = 14;
        tbl[4].hi_r = 14; tbl[4].hi_g = 14; tbl[4].hi_b = 14;
`endif
        for (int i = 0; i < 8; i++) begin
            hr = 0; hg = 0; hb = 0;
            for (int j = 0; j < tbl[i].n; j++) begin
                cycle(tbl[i].rst, tbl[i].en);
                if (j >= tbl[i].n - PER) begin
                    hr += int'(o_led_r); hg += int'(o_led_g); hb += int'(o_led_b);
                end
            end
            check($sformatf("tbl%0d_busy", i), o_busy, tbl[i].busy);
            if (tbl[i].hi_r >= 0) check($sformatf("tbl%0d_hi_r", i), hr, tbl[i].hi_r);
            if (tbl[i].hi_g >= 0) check($sformatf("tbl%0d_hi_g", i), hg, tbl[i].hi_g);
            if (tbl[i].hi_b >= 0) check($sformatf("tbl%0d_hi_b", i), hb, tbl[i].hi_b);
        end
        k = 0;
        while (m_lvl[0] != 6 && k < 200) begin
            cycle(1'b1, 3'b001);
            k++;
        end
        if (m_lvl[0] != 6) begin
            n_chk++; n_fail++;
            $display("FAIL rev_reach: model level %0d expected 6 within 200 cycles", m_lvl[0]);
        end
        hi = 0;
        for (int j = 0; j < PER; j++) begin
            cycle(1'b1, 3'b000);
            hi += int'(o_led_r);
        end
        check("rev_max_hi", hi <= duty(6), 1);
        for (int j = 0; j < 16; j++) cycle(1'b1, 3'b000);
        check("rev_off_busy", o_busy, 1'b0);
        hi = 0;
        for (int j = 0; j < PER; j++) begin
            cycle(1'b1, 3'b000);
            hi += int'(o_led_r);
        end
        check("rev_off_hi", hi, 0);
        k = 0;
        while (k < 3000) begin
            int n;
            n = $urandom_range(1, 40);
            en = 3'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                cycle(1'b0, en);
                k++;
            end
            for (int j = 0; j < n; j++) cycle(1'b1, en);
            k += n;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
